stochastic_to_binary: RTL

STOCHASTIC_TO_BINARY -- requirements
Module: stochastic_to_binary

---
 rtl/stochastic_to_binary_pkg.sv | 16 +
 rtl/s2b_window_counter.sv | 42 ++++
 rtl/sys_defs.svh | 7 +
 rtl/stochastic_to_binary.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/stochastic_to_binary_pkg.sv
// Shared types and constants for the stochastic-to-binary converter.
// Window length derives from `BIN_LEN in sys_defs.svh.
package stochastic_to_binary_pkg;

`include "sys_defs.svh"

  localparam int unsigned BIN_LEN    = `BIN_LEN;
  localparam int unsigned WINDOW_LEN = 32'd1 << BIN_LEN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    WAIT  = 2'd2
  } s2b_state_e;

endpackage

// File: rtl/s2b_window_counter.sv
// Counts ones and samples over a 2^W sample window; done flags the cycle
// whose enabled sample is the last one of the window.
module s2b_window_counter
  import stochastic_to_binary_pkg::*;
#(
  parameter int W = BIN_LEN
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic         in_bit,
  output logic [W:0]   count,
  output logic         done
);

  localparam logic [W:0] LAST_SAMPLE = {1'b0, {W{1'b1}}};

  logic [W:0] ones_r;
  logic [W:0] samples_r;

  // Ones and sample accumulators; clear wins over a same-cycle sample.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ones_r    <= {(W+1){1'b0}};
      samples_r <= {(W+1){1'b0}};
    end else if (clear) begin
      ones_r    <= {(W+1){1'b0}};
      samples_r <= {(W+1){1'b0}};
    end else if (enable) begin
      ones_r    <= ones_r + {{W{1'b0}}, in_bit};
      samples_r <= samples_r + {{W{1'b0}}, 1'b1};
    end else begin
      ones_r    <= ones_r;
      samples_r <= samples_r;
    end
  end

  assign count = ones_r;
  assign done  = enable && (samples_r == LAST_SAMPLE);

endmodule

// File: rtl/sys_defs.svh
// System-wide defines shared by the stochastic computing datapath.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define BIN_LEN 8

`endif

// File: rtl/stochastic_to_binary.sv
// Stochastic bitstream to binary converter with a valid/ready result register.
// Define S2B_OVERRUN_EN to overwrite unconsumed results and flag a sticky overrun.
module stochastic_to_binary
  import stochastic_to_binary_pkg::*;
#(
  parameter int W = BIN_LEN
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         in_bit,
  input  logic         start,
  output logic [W-1:0] out_val,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
`ifdef S2B_OVERRUN_EN
  ,
  output logic         overrun
`endif
);

  s2b_state_e   state_r;
  logic [W-1:0] out_val_r;
  logic         out_valid_r;
  logic         busy_r;
`ifdef S2B_OVERRUN_EN
  logic         overrun_r;
`else
  logic [W-1:0] pending_r;
`endif

  logic         cnt_clear;
  logic         cnt_enable;
  logic [W:0]   cnt_count;
  logic         cnt_done;
  logic [W:0]   ones_final;
  logic [W-1:0] result;
  logic         reg_free;

  // Only a full window of ones reaches 2^W, which must clamp to all-ones.
  function automatic logic [W-1:0] saturate(input logic [W:0] value);
    return value[W] ? {W{1'b1}} : value[W-1:0];
  endfunction

  s2b_window_counter #(.W(W)) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .in_bit (in_bit),
    .count  (cnt_count),
    .done   (cnt_done)
  );

  // Counter control: clear whenever a fresh window may begin next cycle.
  always_comb begin
    cnt_enable = 1'b0;
    cnt_clear  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_clear = start;
      end
      COUNT: begin
        cnt_enable = enable;
        cnt_clear  = cnt_done;
      end
      WAIT: begin
        cnt_clear = out_ready;
      end
      default: begin
        cnt_clear = 1'b1;
      end
    endcase
  end

  assign ones_final = cnt_count + {{W{1'b0}}, in_bit};
  assign result     = saturate(ones_final);
  assign reg_free   = !out_valid_r || out_ready;

  // Control FSM and result register; a consumed result drops out_valid
  // unless a new one loads on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      out_val_r   <= {W{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef S2B_OVERRUN_EN
      overrun_r   <= 1'b0;
`else
      pending_r   <= {W{1'b0}};
`endif
    end else begin
      if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      case (state_r)
        IDLE: begin
          state_r <= start ? COUNT : IDLE;
          busy_r  <= start;
        end
        COUNT: begin
          if (cnt_done) begin
            if (reg_free) begin
              out_val_r   <= result;
              out_valid_r <= 1'b1;
              state_r     <= start ? COUNT : IDLE;
              busy_r      <= start;
            end else begin
`ifdef S2B_OVERRUN_EN
              out_val_r   <= result;
              out_valid_r <= 1'b1;
              overrun_r   <= 1'b1;
              state_r     <= start ? COUNT : IDLE;
              busy_r      <= start;
`else
              pending_r   <= result;
              state_r     <= WAIT;
              busy_r      <= 1'b1;
`endif
            end
          end else begin
            state_r <= COUNT;
            busy_r  <= 1'b1;
          end
        end
        WAIT: begin
`ifdef S2B_OVERRUN_EN
          state_r <= IDLE;
          busy_r  <= 1'b0;
`else
          if (out_ready) begin
            out_val_r   <= pending_r;
            out_valid_r <= 1'b1;
            state_r     <= start ? COUNT : IDLE;
            busy_r      <= start;
          end else begin
            state_r <= WAIT;
            busy_r  <= 1'b1;
          end
`endif
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out_val   = out_val_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
`ifdef S2B_OVERRUN_EN
  assign overrun   = overrun_r;
`endif

endmodule
